lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the core's MEM stage and the single-port byte-enabled data RAM.

---
 rtl/lsu_mem_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a single-port byte-enabled data RAM.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of force-aligning them.
module lsu_mem_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [4:0]       resp_rd,
    output logic             resp_err,
    output logic [DEPTH-1:0] ram_address,
    output logic [3:0]       ram_byteena,
    output logic [WIDTH-1:0] ram_data,
    output logic             ram_wren,
    input  logic [WIDTH-1:0] ram_q,
    output logic [1:0]       state_dbg
);

    // Handshake: a request transfers on a clock edge where req_valid & req_ready,
    // a response transfers where resp_valid & resp_ready; the offering side holds
    // its payload stable until the transfer happens.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             funct_ok;
    logic             align_err;
    logic             req_err;
    logic [1:0]       size;
    logic [1:0]       eff_off;
    logic [3:0]       lane_be;
    logic [WIDTH-1:0] lane_data;

    logic [1:0]       off_q;
    logic [2:0]       funct3_q;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_ext;

    logic             unused_bits;

    assign size        = req_funct3[1:0];
    assign req_ready   = (state == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state == RESP);
    assign state_dbg   = state;
    assign unused_bits = ^req_addr[31:DEPTH+2];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        funct_ok = 1'b0;
        if (req_we) begin
            funct_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            funct_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                       (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == 2'b01) && req_addr[0]) ||
                        ((size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign align_err  = misaligned;
`else
    assign align_err  = 1'b0;
`endif

    assign req_err = !funct_ok || align_err;

    // Halfwords and words drop their low offset bits; in trap mode the
    // misaligned cases never reach the RAM, so the same offset serves both builds.
    always_comb begin
        eff_off = req_addr[1:0];
        case (size)
            2'b01:   eff_off = {req_addr[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
    end

    always_comb begin
        lane_be   = 4'b1111;
        lane_data = req_wdata;
        case (size)
            2'b00: begin
                lane_be   = 4'b0001 << eff_off;
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_be   = eff_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_be   = 4'b1111;
                lane_data = req_wdata;
            end
        endcase
    end

    // The RAM port is only active in the accept cycle of a legal access.
    always_comb begin
        ram_address = '0;
        ram_byteena = 4'b0000;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (accept && !req_err) begin
            ram_address = req_addr[DEPTH+1:2];
            ram_byteena = lane_be;
            ram_wren    = req_we;
            if (req_we) begin
                ram_data = lane_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction from the RAM's registered output
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = ram_q[7:0];
        case (off_q)
            2'd0:    ld_byte = ram_q[7:0];
            2'd1:    ld_byte = ram_q[15:8];
            2'd2:    ld_byte = ram_q[23:16];
            default: ld_byte = ram_q[31:24];
        endcase
        ld_half = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    end

    always_comb begin
        ld_ext = ram_q;
        case (funct3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_ext = {24'd0, ld_byte};
            F3_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = ram_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (!req_we && !req_err) ? RD_WAIT : RESP;
                end
            end
            RD_WAIT: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response payload: captured at accept, load data filled in after RD_WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_rd    <= 5'd0;
            resp_err   <= 1'b0;
            off_q      <= 2'b00;
            funct3_q   <= 3'b000;
        end else begin
            if (accept) begin
                resp_rdata <= '0;
                resp_rd    <= req_rd;
                resp_err   <= req_err;
                off_q      <= eff_off;
                funct3_q   <= req_funct3;
            end else if (state == RD_WAIT) begin
                resp_rdata <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-enabled, registered-output RAM model.
// Expectations follow the build: LSU_MISALIGN_TRAP_EN selects trapping behaviour.
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 10;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [4:0]       req_rd;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic [4:0]       resp_rd;
    logic             resp_err;
    logic [DEPTH-1:0] ram_address;
    logic [3:0]       ram_byteena;
    logic [31:0]      ram_data;
    logic             ram_wren;
    logic [31:0]      ram_q;
    logic [1:0]       state_dbg;

    logic [31:0] mem [0:(1<<DEPTH)-1];
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    lsu_mem_ctrl #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clock       (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    always @(posedge clk) begin
        if (ram_wren) begin
            if (ram_byteena[0]) mem[ram_address][7:0]   <= ram_data[7:0];
            if (ram_byteena[1]) mem[ram_address][15:8]  <= ram_data[15:8];
            if (ram_byteena[2]) mem[ram_address][23:16] <= ram_data[23:16];
            if (ram_byteena[3]) mem[ram_address][31:24] <= ram_data[31:24];
        end
        ram_q <= mem[ram_address];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
    endtask

    task automatic idle_req();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
    endtask

    // One full transaction; called at a negedge, returns at a negedge in IDLE.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [3:0] exp_be, input logic exp_wren, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int hold);
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] held_rdata;
        exp_q.push_back(exp_rdata);
        drive_req(we, f3, addr, wdata, rd);
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".byteena"}, 32'(ram_byteena), 32'(exp_be));
        check({tag, ".wren"}, 32'(ram_wren), 32'(exp_wren));
        if (exp_wren) check({tag, ".ram_data"}, ram_data, exp_wdata);
        @(posedge clk);
        @(negedge clk);
        idle_req();
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        exp_data = exp_q.pop_front();
        check({tag, ".rdata"}, resp_rdata, exp_data);
        check({tag, ".rd"}, 32'(resp_rd), 32'(rd));
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        held_rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_rdata"}, resp_rdata, held_rdata);
            check({tag, ".hold_rd"}, 32'(resp_rd), 32'(rd));
            check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        if (resp_valid) begin
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
        end
        check({tag, ".back_idle"}, 32'(resp_valid), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] w10;
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 32'd0;
        ram_q      = 32'd0;
        reset      = 1'b1;
        resp_ready = 1'b0;
        // A request offered during reset must not reach the RAM.
        drive_req(1'b1, 3'b010, 32'h10, 32'hFFFF_FFFF, 5'd31);
        repeat (3) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_rd", 32'(resp_rd), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.byteena", 32'(ram_byteena), 32'd0);
        check("rst.wren", 32'(ram_wren), 32'd0);
        check("rst.state", 32'(state_dbg), 32'd0);
        idle_req();
        reset = 1'b0;
        @(negedge clk);

        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd1, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 0);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
        do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 5'd3, 4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1, 0);
        do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 0);
        do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 4'b1000, 1'b0, 32'h0, 32'h0000_00A5, 1'b0, 2, 0);
        do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 5'd6, 4'b1111, 1'b0, 32'h0, 32'hA5AD_BEEF, 1'b0, 2, 0);

        if (TRAP) begin
            do_req("sh11", 1'b1, 3'b001, 32'h11, 32'h1234, 5'd7, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
            w10 = 32'hA5AD_BEEF;
        end else begin
            do_req("sh11", 1'b1, 3'b001, 32'h11, 32'h1234, 5'd7, 4'b0011, 1'b1, 32'h1234_1234, 32'h0, 1'b0, 1, 0);
            w10 = 32'hA5AD_1234;
        end
        do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 0);
        do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 5'd9, 4'b1100, 1'b0, 32'h0, 32'hFFFF_A5AD, 1'b0, 2, 0);
        do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 5'd10, 4'b1100, 1'b0, 32'h0, 32'h0000_A5AD, 1'b0, 2, 0);
        // Address bits above DEPTH+1 are ignored, so 0x1010 aliases 0x10.
        do_req("lw_wrap", 1'b0, 3'b010, 32'h0000_1010, 32'h0, 5'd11, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 0);

        if (TRAP) begin
            do_req("lw12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 5'd12, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        end else begin
            do_req("lw12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 5'd12, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 0);
        end

        do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 5'd13, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 5'd14, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lw_after_bad", 1'b0, 3'b010, 32'h10, 32'h0, 5'd15, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 0);

        do_req("hold", 1'b0, 3'b010, 32'h10, 32'h0, 5'd21, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 3);

        // Reset while a load is in RD_WAIT drops the response.
        drive_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
        @(posedge clk);
        @(negedge clk);
        idle_req();
        check("rdw.state", 32'(state_dbg), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rdw.rst_valid", 32'(resp_valid), 32'd0);
        check("rdw.rst_rd", 32'(resp_rd), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rdw.after_valid", 32'(resp_valid), 32'd0);
            check("rdw.after_ready", 32'(req_ready), 32'd1);
        end
        do_req("lw_post_rst", 1'b0, 3'b010, 32'h10, 32'h0, 5'd17, 4'b1111, 1'b0, 32'h0, w10, 1'b0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
